// File: rtl/tof_pkg.sv
// Shared constants for the ToF sensor firmware loader: FSM encoding and the
// default I2C device address / page-select register values.
package tof_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_PG_DEV  = 4'd1;
    localparam logic [3:0] ST_PG_RH   = 4'd2;
    localparam logic [3:0] ST_PG_RL   = 4'd3;
    localparam logic [3:0] ST_PG_VAL  = 4'd4;
    localparam logic [3:0] ST_FW_DEV  = 4'd5;
    localparam logic [3:0] ST_FW_RH   = 4'd6;
    localparam logic [3:0] ST_FW_RL   = 4'd7;
    localparam logic [3:0] ST_FW_DATA = 4'd8;
    localparam logic [3:0] ST_FIN     = 4'd9;

    localparam logic [6:0]  TOF_DEV_ADDR  = 7'h29;
    localparam logic [15:0] TOF_PAGE_REG  = 16'h7FFF;
    localparam logic [7:0]  TOF_PAGE_BASE = 8'h09;

endpackage

// File: rtl/tof_fw_loader.sv
// Streams firmware from an external ROM to a ToF sensor over I2C, one page-select
// write followed by one data burst per chunk. Optional fw_sum via TOF_FW_LOADER_CHECKSUM_EN.
module tof_fw_loader
    import tof_pkg::*;
#(
    parameter int unsigned FW_SIZE     = 86000,
    parameter int unsigned CHUNK_BYTES = 32768,
    parameter logic [6:0]  DEV_ADDR    = TOF_DEV_ADDR,
    parameter logic [15:0] PAGE_REG    = TOF_PAGE_REG,
    parameter logic [7:0]  PAGE_BASE   = TOF_PAGE_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [16:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    input  logic        i2c_nack
`ifdef TOF_FW_LOADER_CHECKSUM_EN
   ,output logic [15:0] fw_sum
`endif
);

    logic [3:0]  state_r;
    logic [7:0]  k_r;
    logic [16:0] rom_addr_r;
    logic [16:0] cnt_r;
    logic        last_chunk_r;
    logic        done_r;
    logic        error_r;
    logic        accept_s;
    logic [31:0] rem_s;
    logic [16:0] len_m1_s;
    logic        last_chunk_s;

    assign accept_s = tx_valid && tx_ready;
    assign rom_addr = rom_addr_r;
    assign done     = done_r;
    assign error    = error_r;
    assign busy     = (state_r != ST_IDLE);
    assign tx_valid = (state_r != ST_IDLE) && (state_r != ST_FIN);

    // Chunk length (minus one) and final-chunk flag, decided without wrapping at 2^17
    always_comb begin
        rem_s = FW_SIZE - {15'd0, rom_addr_r};
        if (rem_s <= CHUNK_BYTES) begin
            len_m1_s     = 17'(rem_s - 32'd1);
            last_chunk_s = 1'b1;
        end else begin
            len_m1_s     = 17'(CHUNK_BYTES - 32'd1);
            last_chunk_s = 1'b0;
        end
    end

    // Byte presented to the I2C master in each transfer state
    always_comb begin
        tx_data = 8'h00;
        tx_last = 1'b0;
        case (state_r)
            ST_PG_DEV, ST_FW_DEV: tx_data = {DEV_ADDR, 1'b0};
            ST_PG_RH:             tx_data = PAGE_REG[15:8];
            ST_PG_RL:             tx_data = PAGE_REG[7:0];
            ST_PG_VAL: begin
                tx_data = PAGE_BASE + k_r;
                tx_last = 1'b1;
            end
            ST_FW_RH, ST_FW_RL:   tx_data = 8'h00;
            ST_FW_DATA: begin
                tx_data = rom_data;
                tx_last = (cnt_r == 17'd0);
            end
            default: begin
                tx_data = 8'h00;
                tx_last = 1'b0;
            end
        endcase
    end

    // Transfer FSM; a NACK in any active state aborts, even on an accepted byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            k_r          <= 8'd0;
            rom_addr_r   <= 17'd0;
            cnt_r        <= 17'd0;
            last_chunk_r <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else if ((state_r != ST_IDLE) && i2c_nack) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            error_r <= 1'b1;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_PG_DEV;
                        k_r        <= 8'd0;
                        rom_addr_r <= 17'd0;
                    end
                end
                ST_PG_DEV: if (accept_s) state_r <= ST_PG_RH;
                ST_PG_RH:  if (accept_s) state_r <= ST_PG_RL;
                ST_PG_RL:  if (accept_s) state_r <= ST_PG_VAL;
                ST_PG_VAL: if (accept_s) state_r <= ST_FW_DEV;
                ST_FW_DEV: if (accept_s) state_r <= ST_FW_RH;
                ST_FW_RH:  if (accept_s) state_r <= ST_FW_RL;
                ST_FW_RL: begin
                    if (accept_s) begin
                        state_r      <= ST_FW_DATA;
                        cnt_r        <= len_m1_s;
                        last_chunk_r <= last_chunk_s;
                    end
                end
                ST_FW_DATA: begin
                    if (accept_s) begin
                        rom_addr_r <= rom_addr_r + 17'd1;
                        cnt_r      <= cnt_r - 17'd1;
                        if (cnt_r == 17'd0) begin
                            if (last_chunk_r) begin
                                state_r <= ST_FIN;
                            end else begin
                                k_r     <= k_r + 8'd1;
                                state_r <= ST_PG_DEV;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b1;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef TOF_FW_LOADER_CHECKSUM_EN
    logic [15:0] sum_r;
    assign fw_sum = sum_r;

    // Running sum of firmware bytes the master actually accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 16'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            sum_r <= 16'd0;
        end else if ((state_r == ST_FW_DATA) && accept_s && !i2c_nack) begin
            sum_r <= sum_r + {8'd0, rom_data};
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

endmodule

// File: tb/tb_tof_fw_loader.sv
// Scoreboard bench for tof_fw_loader with a 5-byte image in 3-byte chunks.
module tb_tof_fw_loader;

    logic        clk = 1'b0;
    logic        rst, start, tx_ready, i2c_nack;
    logic        busy, done, error, tx_valid, tx_last;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data, tx_data;
`ifdef TOF_FW_LOADER_CHECKSUM_EN
    logic [15:0] fw_sum;
`endif

    assign rom_data = 8'(rom_addr + 17'd1);

    tof_fw_loader #(.FW_SIZE(5), .CHUNK_BYTES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .rom_addr(rom_addr), .rom_data(rom_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_last(tx_last), .i2c_nack(i2c_nack)
`ifdef TOF_FW_LOADER_CHECKSUM_EN
       ,.fw_sum(fw_sum)
`endif
    );

    always #5 clk = ~clk;

    // {tx_last, tx_data} for the full hand-computed transfer
    logic [8:0] exp_tbl [0:18] = '{
        9'h052, 9'h07F, 9'h0FF, 9'h109,
        9'h052, 9'h000, 9'h000, 9'h001, 9'h002, 9'h103,
        9'h052, 9'h07F, 9'h0FF, 9'h10A,
        9'h052, 9'h000, 9'h000, 9'h004, 9'h105 };

    logic [8:0] exp_q [$];
    int total_cnt = 0, pass_cnt = 0;
    int acc_cnt = 0, done_cnt = 0, error_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_tbl[i]);
        acc_cnt = 0; done_cnt = 0; error_cnt = 0;
    endtask

    // Monitor: pops on every accepted byte, checks stall stability, counts pulses
    initial begin
        logic       prev_stall;
        logic [8:0] prev_byte;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_byte  = 9'h000;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (done)  done_cnt++;
                if (error) error_cnt++;
                if (tx_valid && prev_stall) chk("stall_stable", {23'd0, tx_last, tx_data}, {23'd0, prev_byte});
                if (tx_valid && tx_ready && !i2c_nack) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_byte: got %0h required none", {tx_last, tx_data});
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", {23'd0, tx_last, tx_data}, {23'd0, e});
                    end
                    acc_cnt++;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_byte  = {tx_last, tx_data};
            end
        end
    end

    task automatic wait_acc(input int n);
        int cyc = 0;
        while (acc_cnt < n && cyc < 200) begin tick(); cyc++; end
        if (cyc >= 200) begin
            total_cnt++;
            $display("FAIL acc_timeout: got %0d bytes required %0d", acc_cnt, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
        chk({tag, "_tx_last"},  {31'd0, tx_last},  32'd0);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_error"},    {31'd0, error},    32'd0);
        chk({tag, "_rom_addr"}, {15'd0, rom_addr}, 32'd0);
    endtask

    task automatic run_seq(input bit toggle, input bit dbl_start);
        int cyc = 0;
        push_exp(19);
        tx_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (done_cnt == 0 && cyc < 400) begin
            if (toggle) tx_ready = ~tx_ready;
            start = (dbl_start && cyc == 5);
            tick();
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 400) begin
            total_cnt++;
            $display("FAIL done_timeout: got no done required one");
        end
        tx_ready = 1'b1;
        repeat (3) tick();
        chk("done_count",   done_cnt,     32'd1);
        chk("error_count",  error_cnt,    32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("busy_after",   {31'd0, busy}, 32'd0);
`ifdef TOF_FW_LOADER_CHECKSUM_EN
        chk("fw_sum", {16'd0, fw_sum}, 32'h0000000F);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0; i2c_nack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        run_seq(1'b0, 1'b0);
        run_seq(1'b1, 1'b0);

        // NACK on the second data byte of chunk 0
        push_exp(8);
        tx_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_acc(8);
        i2c_nack = 1'b1;
        tick();
        i2c_nack = 1'b0;
        chk("nack_error",    {31'd0, error},    32'd1);
        chk("nack_busy",     {31'd0, busy},     32'd0);
        chk("nack_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("nack_done",     {31'd0, done},     32'd0);
        repeat (3) tick();
        chk("nack_error_pulses", error_cnt, 32'd1);
        chk("nack_done_pulses",  done_cnt,  32'd0);

        // Reset while the 4th data byte is on the bus
        push_exp(17);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_acc(17);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        run_seq(1'b0, 1'b0);

        run_seq(1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
